// File: rtl/fetch_queue_pkg.sv
// Shared fetch-queue configuration: default geometry and field offsets of a packed entry.
// Entry layout, MSB to LSB: {instr, pc, pc_plus4}.
package fetch_queue_pkg;

  localparam int FQ_DEPTH = 4;
  localparam int FQ_IW    = 32;
  localparam int FQ_AW    = 32;

  localparam int FQ_PC4_LSB = 0;

  function automatic int fq_pc_lsb(input int aw);
    return aw;
  endfunction

  function automatic int fq_instr_lsb(input int aw);
    return 2 * aw;
  endfunction

  function automatic int fq_entry_w(input int iw, input int aw);
    return iw + 2 * aw;
  endfunction

endpackage

// File: rtl/fetch_queue_storage.sv
// DEPTH x EW register array: one write port, one async read port, sync clear (write wins).
// Zero latency on the read port; no flow control of its own.
module fetch_queue_storage #(
  parameter int EW    = 96,
  parameter int DEPTH = 4,
  parameter int PW    = 2
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          clr,
  input  logic          wr_vld,
  input  logic [PW-1:0] wr_addr,
  input  logic [EW-1:0] wr_dat,
  input  logic [PW-1:0] rd_addr,
  output logic [EW-1:0] rd_dat
);

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = clr ? '0 : mem_q[i];
    end
    if (wr_vld) begin
      mem_d[wr_addr] = wr_dat;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// IF->ID instruction queue (circular buffer); 1-cycle write-to-read latency, no IN->OUT comb path.
// Backpressure: IN_READY = COUNT<DEPTH (or FLUSH); a same-cycle pop never frees a slot for a push.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int IW    = FQ_IW,
  parameter int AW    = FQ_AW,
  parameter int DEPTH = FQ_DEPTH
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       FLUSH,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  input  logic [IW-1:0]              IN_INSTR,
  input  logic [AW-1:0]              IN_PC,
  input  logic [AW-1:0]              IN_PC_PLUS4,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic [IW-1:0]              OUT_INSTR,
  output logic [AW-1:0]              OUT_PC,
  output logic [AW-1:0]              OUT_PC_PLUS4,
  output logic [$clog2(DEPTH+1)-1:0] COUNT
);

  localparam int PW        = $clog2(DEPTH);
  localparam int CW        = $clog2(DEPTH + 1);
  localparam int EW        = fq_entry_w(IW, AW);
  localparam int PC_LSB    = fq_pc_lsb(AW);
  localparam int INSTR_LSB = fq_instr_lsb(AW);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          push;
  logic          pop;
  logic [PW-1:0] wr_addr;
  logic [EW-1:0] wr_dat;
  logic [EW-1:0] rd_dat;

  // FLUSH forces readiness so the redirect target is always captured.
  assign IN_READY  = FLUSH | (count_q != FULL_CNT);
  assign OUT_VALID = (count_q != '0);
  assign COUNT     = count_q;

  assign push    = IN_VALID & IN_READY;
  assign pop     = OUT_VALID & OUT_READY & ~FLUSH;
  assign wr_addr = FLUSH ? '0 : tail_q;
  assign wr_dat  = {IN_INSTR, IN_PC, IN_PC_PLUS4};

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (FLUSH) begin
      head_d  = '0;
      tail_d  = push ? PW'(1) : '0;
      count_d = push ? CW'(1) : '0;
    end else begin
      if (push) begin
        tail_d = tail_q + PW'(1);
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  fetch_queue_storage #(
    .EW    (EW),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_storage (
    .CLK     (CLK),
    .RESET   (RESET),
    .clr     (FLUSH),
    .wr_vld  (push),
    .wr_addr (wr_addr),
    .wr_dat  (wr_dat),
    .rd_addr (head_q),
    .rd_dat  (rd_dat)
  );

  assign OUT_INSTR    = OUT_VALID ? rd_dat[INSTR_LSB +: IW] : '0;
  assign OUT_PC       = OUT_VALID ? rd_dat[PC_LSB +: AW] : '0;
  assign OUT_PC_PLUS4 = OUT_VALID ? rd_dat[FQ_PC4_LSB +: AW] : '0;

endmodule
